psg_tone_scheduler: RTL and testbench

- Holds per-channel tone period and attenuation registers for the three PSG tone channels, loaded by the command decoder's write strobes.
- Time-shares one down-counter datapath across the channels, one channel serviced per clock after each prescaler tick.
- Produces square-wave tone bits, per-channel attenuation and a sample strobe for the downstream mixer/DAC stage.

---
 rtl/psg_pkg.sv | 20 ++
 rtl/psg_prescaler.sv | 32 +++
 rtl/psg_tone_scheduler.sv | 147 ++++++++++++++
 tb/tb_psg_tone_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// rtl/psg_pkg.sv - shared types and constants for the PSG tone scheduler
//
// Purpose: scheduler state encoding, default channel/period sizing and the
//          silent attenuation code used by psg_tone_scheduler.
// Ports:   none (package).
package psg_pkg;

    localparam int         NUM_CH       = 3;
    localparam int         FREQ_W       = 10;
    localparam logic [3:0] ATTEN_SILENT = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SVC,
        DONE
    } sched_state_t;

    typedef logic [$clog2(NUM_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/psg_prescaler.sv
// rtl/psg_prescaler.sv - free-running tone-tick prescaler
//
// Purpose: counts 0..PRESCALE-1 and flags the last count as the tone tick.
// Ports:   clk   - system clock
//          reset - asynchronous, active-high reset
//          tick  - high for the one cycle in which the count is PRESCALE-1
module psg_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int               CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/psg_tone_scheduler.sv
// rtl/psg_tone_scheduler.sv - time-shared tone counter scheduler for PSG channels
//
// Purpose: holds per-channel period and attenuation registers and services one
//          channel per clock after each prescaler tick, producing square-wave
//          tone bits and a per-tick sample strobe.
// Ports:   clk           - system clock
//          reset         - asynchronous, active-high reset
//          enable        - one-hot period write strobe, qualifies freq
//          freq          - period value
//          atten_enable  - one-hot attenuation write strobe, qualifies atten_mag
//          atten_mag     - attenuation value
//          tone_out      - registered square-wave bit per channel
//          atten_out     - registered attenuation, ch k at [4k+3:4k]
//          sample_strobe - one-cycle pulse once every channel has been serviced
//          busy          - high while the scheduler is not idle
module psg_tone_scheduler #(
    parameter int PRESCALE = 16,
    parameter int NUM_CH   = psg_pkg::NUM_CH,
    parameter int FREQ_W   = psg_pkg::FREQ_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   enable,
    input  logic [FREQ_W-1:0]   freq,
    input  logic [NUM_CH-1:0]   atten_enable,
    input  logic [3:0]          atten_mag,
    output logic [NUM_CH-1:0]   tone_out,
    output logic [4*NUM_CH-1:0] atten_out,
    output logic                sample_strobe,
    output logic                busy
);

    import psg_pkg::*;

    // The walk over all channels must finish before the next tick arrives,
    // and the channel index must be wide enough to address every channel.
    if (PRESCALE < NUM_CH + 2) begin : g_bad_prescale
        $error("psg_tone_scheduler: PRESCALE must be >= NUM_CH+2");
    end
    if (NUM_CH > (1 << $bits(ch_idx_t))) begin : g_bad_num_ch
        $error("psg_tone_scheduler: NUM_CH exceeds channel index width");
    end

    localparam ch_idx_t           LAST_CH  = ch_idx_t'(NUM_CH - 1);
    localparam logic [FREQ_W-1:0] FREQ_ONE = FREQ_W'(1);

    logic                          tick;
    sched_state_t                  state, state_next;
    ch_idx_t                       ch, ch_next;
    logic [NUM_CH-1:0][FREQ_W-1:0] period;
    logic [NUM_CH-1:0][FREQ_W-1:0] count;

    psg_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
        end
    end

    always_comb begin
        state_next = state;
        ch_next    = ch;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = SVC;
                    ch_next    = '0;
                end
            end
            SVC: begin
                if (ch == LAST_CH) begin
                    state_next = DONE;
                end else begin
                    ch_next = ch + ch_idx_t'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sample_strobe = (state == DONE);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (enable[k]) begin
                    period[k] <= freq;
                end
            end
        end
    end

    // Service reads period[] before the write on the same edge lands, so a
    // colliding write only affects the following reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            tone_out <= '0;
        end else if (state == SVC) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch == ch_idx_t'(k)) begin
                    if (period[k] <= FREQ_ONE) begin
                        tone_out[k] <= 1'b1;
                        count[k]    <= '0;
                    end else if (count[k] <= FREQ_ONE) begin
                        tone_out[k] <= ~tone_out[k];
                        count[k]    <= period[k];
                    end else begin
                        count[k] <= count[k] - FREQ_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            atten_out <= {NUM_CH{ATTEN_SILENT}};
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (atten_enable[k]) begin
                    atten_out[4*k +: 4] <= atten_mag;
                end
            end
        end
    end

    a_no_tick_when_busy : assert property (
        @(posedge clk) disable iff (reset) !(tick && busy)
    ) else $error("psg_tone_scheduler: tick while scheduler busy");

endmodule

// File: tb/tb_psg_tone_scheduler.sv
// tb/tb_psg_tone_scheduler.sv - directed self-checking bench for psg_tone_scheduler
module tb_psg_tone_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  enable = '0;
    logic [9:0]  freq = '0;
    logic [2:0]  atten_enable = '0;
    logic [3:0]  atten_mag = '0;
    logic [2:0]  tone_out;
    logic [11:0] atten_out;
    logic        sample_strobe;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    psg_tone_scheduler #(
        .PRESCALE(16),
        .NUM_CH  (3),
        .FREQ_W  (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .freq         (freq),
        .atten_enable (atten_enable),
        .atten_mag    (atten_mag),
        .tone_out     (tone_out),
        .atten_out    (atten_out),
        .sample_strobe(sample_strobe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic exp_strobe(input int c);
        return (c >= 19) && (((c - 19) % 16) == 0);
    endfunction

    function automatic logic exp_busy(input int c);
        return (c >= 16) && (((c - 16) % 16) < 4);
    endfunction

    // Tone with every period at 0: channel k goes DC-high in cycle 17+k.
    function automatic logic [2:0] exp_tone_dc(input int c);
        logic [2:0] t;
        for (int k = 0; k < 3; k++) t[k] = (c >= 17 + k);
        return t;
    endfunction

    initial begin
        logic [2:0]  tone_exp;
        logic        tone_chk;
        logic [11:0] atten_exp;

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_tone", 32'(tone_out), 32'h0);
        check_val("rst_atten", 32'(atten_out), 32'hFFF);
        check_val("rst_strobe", 32'(sample_strobe), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;

        for (int c = 0; c <= 16721; c++) begin
            enable       = '0;
            atten_enable = '0;
            case (c)
                40:    begin enable = 3'b001; freq = 10'd2;   end
                120:   begin enable = 3'b001; freq = 10'd1;   end
                121:   begin enable = 3'b010; freq = 10'd3;   end
                122:   begin enable = 3'b100; freq = 10'h3FF; end
                16500: begin enable = 3'b010; freq = 10'd2;   end
                16545: begin enable = 3'b010; freq = 10'd5;   end
                16700: begin atten_enable = 3'b100; atten_mag = 4'h3; end
                default: ;
            endcase

            check_val("strobe", 32'(sample_strobe), 32'(exp_strobe(c)));
            check_val("busy", 32'(busy), 32'(exp_busy(c)));
            atten_exp = (c >= 16701) ? 12'h3FF : 12'hFFF;
            check_val("atten", 32'(atten_out), 32'(atten_exp));

            tone_chk = 1'b1;
            tone_exp = '0;
            if (c <= 40) begin
                tone_exp = exp_tone_dc(c);
            end else begin
                case (c)
                    48:    tone_exp = 3'b111;
                    49:    tone_exp = 3'b110;
                    80:    tone_exp = 3'b110;
                    81:    tone_exp = 3'b111;
                    113:   tone_exp = 3'b110;
                    128:   tone_exp = 3'b110;
                    129:   tone_exp = 3'b111;
                    130:   tone_exp = 3'b101;
                    131:   tone_exp = 3'b001;
                    177:   tone_exp = 3'b001;
                    178:   tone_exp = 3'b011;
                    226:   tone_exp = 3'b001;
                    16497: tone_exp = 3'b001;
                    16498: tone_exp = 3'b011;
                    16499: tone_exp = 3'b111;
                    16545: tone_exp = 3'b111;
                    16546: tone_exp = 3'b101;
                    16577: tone_exp = 3'b101;
                    16578: tone_exp = 3'b111;
                    16657: tone_exp = 3'b111;
                    16658: tone_exp = 3'b101;
                    16700: tone_exp = 3'b101;
                    16701: tone_exp = 3'b101;
                    default: tone_chk = 1'b0;
                endcase
            end
            if (tone_chk) check_val("tone", 32'(tone_out), 32'(tone_exp));

            if (c < 16721) step();
        end

        // Cycle 16721 is the service cycle of ch1; reset lands mid-walk.
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'h0);
        check_val("mid_rst_tone", 32'(tone_out), 32'h0);
        check_val("mid_rst_atten", 32'(atten_out), 32'hFFF);
        check_val("mid_rst_strobe", 32'(sample_strobe), 32'h0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;

        for (int c = 0; c <= 24; c++) begin
            check_val("post_strobe", 32'(sample_strobe), 32'(exp_strobe(c)));
            check_val("post_busy", 32'(busy), 32'(exp_busy(c)));
            check_val("post_tone", 32'(tone_out), 32'(exp_tone_dc(c)));
            check_val("post_atten", 32'(atten_out), 32'hFFF);
            if (c < 24) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
